// File: rtl/qspi_sram_pkg.sv
// Shared definitions for the QSPI SRAM responder: opcodes, FSM encoding, dummy-cycle count.
package qspi_sram_pkg;
  localparam logic [7:0] OP_READ   = 8'h03;
  localparam logic [7:0] OP_WRITE  = 8'h02;
  localparam logic [7:0] OP_EQIO   = 8'h38;
  localparam logic [7:0] OP_RSTQIO = 8'hFF;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_DUMMY  = 3'd3;
  localparam logic [2:0] ST_RDATA  = 3'd4;
  localparam logic [2:0] ST_WDATA  = 3'd5;
  localparam logic [2:0] ST_IGNORE = 3'd6;

  localparam int DUMMY_CYC = 2;

  // Index of the last sck rise in the current field (bits in SPI, nibbles in SQI).
  function automatic logic [4:0] shift_limit(input logic [2:0] st, input logic sqi);
    case (st)
      ST_CMD, ST_RDATA, ST_WDATA: shift_limit = sqi ? 5'd1 : 5'd7;
      ST_ADDR:                    shift_limit = sqi ? 5'd5 : 5'd23;
      ST_DUMMY:                   shift_limit = 5'(DUMMY_CYC - 1);
      default:                    shift_limit = 5'd0;
    endcase
  endfunction
endpackage

// File: rtl/qspi_resp_mem.sv
// Byte array with one synchronous write port and one registered read port; never cleared.
module qspi_resp_mem #(
  parameter int MEM_ADDR_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      i_we,
  input  logic [MEM_ADDR_WIDTH-1:0] i_waddr,
  input  logic [7:0]                i_wdata,
  input  logic [MEM_ADDR_WIDTH-1:0] i_raddr,
  output logic [7:0]                o_rdata
);
  logic [7:0] r_mem [0:(1<<MEM_ADDR_WIDTH)-1];
  logic [7:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/qspi_sram_responder.sv
// QSPI/SPI serial SRAM responder, oversampled in the clk domain.
// QSPI_RESP_SPI_RW_EN: when defined, READ/WRITE are also accepted in SPI mode.
module qspi_sram_responder
  import qspi_sram_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sram_cs_n,
  input  logic       sram_sck,
  input  logic [3:0] sram_sio_i,
  output logic [3:0] sram_sio_o,
  output logic       sram_sio_oe
);
  logic [SYNC_STAGES-1:0][5:0] r_sync;
  logic                        r_cs_d, r_sck_d;
  logic [2:0]                  r_state;
  logic                        r_mode, r_is_rd;
  logic [4:0]                  r_cnt;
  logic [23:0]                 r_sh;
  logic [MEM_ADDR_WIDTH-1:0]   r_addr;
  logic [3:0]                  r_sio_o;
  logic                        w_cs, w_sck, w_sck_rise, w_cs_fall, w_last, w_byte_done, w_we, w_rw_ok;
  logic [3:0]                  w_sio;
  logic [23:0]                 w_sh_nxt;
  logic [7:0]                  w_rdata;
  logic                        w_unused;

  // cs_n, sck and sio share one synchronizer chain so they stay cycle-aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync  <= {SYNC_STAGES{6'b10_0000}};
      r_cs_d  <= 1'b1;
      r_sck_d <= 1'b0;
    end else begin
      r_sync[0] <= {sram_cs_n, sram_sck, sram_sio_i};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_cs_d  <= w_cs;
      r_sck_d <= w_sck;
    end
  end

  assign w_cs        = r_sync[SYNC_STAGES-1][5];
  assign w_sck       = r_sync[SYNC_STAGES-1][4];
  assign w_sio       = r_sync[SYNC_STAGES-1][3:0];
  assign w_sck_rise  = w_sck & ~r_sck_d;
  assign w_cs_fall   = r_cs_d & ~w_cs;
  assign w_sh_nxt    = r_mode ? {r_sh[19:0], w_sio} : {r_sh[22:0], w_sio[0]};
  assign w_last      = (r_cnt == shift_limit(r_state, r_mode));
  assign w_byte_done = w_sck_rise & w_last;
  // Not gated by cs_n so a byte completing as cs_n rises still lands.
  assign w_we        = (r_state == ST_WDATA) & w_byte_done;
  assign w_unused    = r_sh[23];

`ifdef QSPI_RESP_SPI_RW_EN
  assign w_rw_ok = 1'b1;
`else
  assign w_rw_ok = r_mode;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_mode  <= 1'b0;
      r_is_rd <= 1'b0;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_addr  <= '0;
    end else begin
      if (w_sck_rise) begin
        r_sh  <= w_sh_nxt;
        r_cnt <= w_last ? 5'd0 : r_cnt + 5'd1;
      end
      case (r_state)
        ST_IDLE: if (w_cs_fall) begin
          r_state <= ST_CMD;
          r_cnt   <= '0;
        end
        ST_CMD: if (w_byte_done) begin
          case (w_sh_nxt[7:0])
            OP_READ, OP_WRITE: begin
              r_state <= w_rw_ok ? ST_ADDR : ST_IGNORE;
              r_is_rd <= (w_sh_nxt[7:0] == OP_READ);
            end
            OP_EQIO:   begin r_mode <= 1'b1; r_state <= ST_IGNORE; end
            OP_RSTQIO: begin r_mode <= 1'b0; r_state <= ST_IGNORE; end
            default:   r_state <= ST_IGNORE;
          endcase
        end
        ST_ADDR: if (w_byte_done) begin
          r_addr  <= w_sh_nxt[MEM_ADDR_WIDTH-1:0];
          r_state <= !r_is_rd ? ST_WDATA : (r_mode ? ST_DUMMY : ST_RDATA);
        end
        ST_DUMMY: if (w_byte_done) r_state <= ST_RDATA;
        ST_RDATA, ST_WDATA: if (w_byte_done) r_addr <= r_addr + 1'b1;
        default: ;
      endcase
      if (w_cs && r_state != ST_IDLE) r_state <= ST_IDLE;
    end
  end

  // Output only moves while sck is low, so it is stable across each sampling rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                r_sio_o <= '0;
    else if (r_state != ST_RDATA) r_sio_o <= '0;
    else if (!w_sck)
      r_sio_o <= r_mode ? (r_cnt[0] ? w_rdata[3:0] : w_rdata[7:4])
                        : {2'b00, w_rdata[3'd7 - r_cnt[2:0]], 1'b0};
  end

  qspi_resp_mem #(.MEM_ADDR_WIDTH(MEM_ADDR_WIDTH)) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_addr),
    .i_wdata (w_sh_nxt[7:0]),
    .i_raddr (r_addr),
    .o_rdata (w_rdata)
  );

  assign sram_sio_o  = r_sio_o;
  assign sram_sio_oe = (r_state == ST_RDATA);
endmodule

// File: tb/tb_qspi_sram_responder.sv
// Directed bench for qspi_sram_responder: mode switching, SQI read/write, wrap, abort, ignore.
module tb_qspi_sram_responder;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cs_n = 1'b1;
  logic       sck = 1'b0;
  logic [3:0] sio_i = 4'h0;
  logic [3:0] sio_o;
  logic       oe;
  int total = 0, bad = 0;
  int oe_hi = 0, oe_bad = 0, we_cnt = 0;

  always #5 clk = ~clk;

  qspi_sram_responder #(.MEM_ADDR_WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sram_cs_n   (cs_n),
    .sram_sck    (sck),
    .sram_sio_i  (sio_i),
    .sram_sio_o  (sio_o),
    .sram_sio_oe (oe)
  );

  always @(posedge clk) begin
    if (oe) oe_hi++;
    if (dut.w_we) we_cnt++;
  end
  always @(negedge clk) if (oe && dut.r_state != 3'd4) oe_bad++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One sck period: data set at start of low phase, outputs sampled just before the rise.
  task automatic beat(input logic [3:0] d, output logic [3:0] so, output logic soe);
    sio_i = d;
    clks(6);
    so  = sio_o;
    soe = oe;
    sck = 1'b1;
    clks(6);
    sck = 1'b0;
  endtask

  task automatic cs_on;
    cs_n = 1'b0;
    clks(4);
  endtask

  task automatic cs_off;
    clks(4);
    cs_n = 1'b1;
    clks(6);
  endtask

  task automatic sqi_byte(input logic [7:0] b);
    logic [3:0] so;
    logic       soe;
    beat(b[7:4], so, soe);
    beat(b[3:0], so, soe);
  endtask

  task automatic spi_byte(input logic [7:0] b);
    logic [3:0] so;
    logic       soe;
    for (int i = 7; i >= 0; i--) beat({3'b000, b[i]}, so, soe);
  endtask

  task automatic sqi_hdr(input logic [7:0] op, input logic [23:0] a);
    cs_on;
    sqi_byte(op);
    sqi_byte(a[23:16]);
    sqi_byte(a[15:8]);
    sqi_byte(a[7:0]);
  endtask

  task automatic sqi_rd(output logic [7:0] b, output logic oe_both);
    logic [3:0] hi, lo;
    logic       e0, e1;
    beat(4'h0, hi, e0);
    beat(4'h0, lo, e1);
    b = {hi, lo};
    oe_both = e0 & e1;
  endtask

  task automatic dummies(input string tag);
    logic [3:0] so;
    logic       soe;
    for (int i = 0; i < 2; i++) begin
      beat(4'h0, so, soe);
      chk(tag, {31'd0, soe}, 32'd0);
    end
  endtask

  initial begin
    logic [3:0] so;
    logic       soe;
    logic [7:0] rb;
    logic [7:0] exp_b;
    int         we0, oe0;

    clks(3);
    chk("rst_sio_o", {28'd0, sio_o}, 32'd0);
    chk("rst_oe", {31'd0, oe}, 32'd0);
    chk("rst_state", {29'd0, dut.r_state}, 32'd0);
    chk("rst_mode", {31'd0, dut.r_mode}, 32'd0);
    reset_n = 1'b1;
    clks(2);

    cs_on; spi_byte(8'h38); cs_off;
    chk("eqio_mode", {31'd0, dut.r_mode}, 32'd1);
    chk("eqio_no_oe", oe_hi, 32'd0);

    sqi_hdr(8'h02, 24'h000010); sqi_byte(8'h12); sqi_byte(8'h34); cs_off;

    cs_on; sqi_byte(8'h03);
    chk("rd_addr_oe", {31'd0, oe}, 32'd0);
    sqi_byte(8'h00); sqi_byte(8'h00); sqi_byte(8'h10);
    dummies("rd_dummy_oe");
    for (int i = 0; i < 4; i++) begin
      beat(4'h0, so, soe);
      chk("rd10_nibble", {28'd0, so}, 32'(i + 1));
      chk("rd10_oe", {31'd0, soe}, 32'd1);
    end
    cs_off;
    chk("rd_oe_after_cs", {31'd0, oe}, 32'd0);

    sqi_hdr(8'h02, 24'h00FFFF); sqi_byte(8'hA1); sqi_byte(8'hB2); sqi_byte(8'hC3); cs_off;
    sqi_hdr(8'h03, 24'h00FFFF); dummies("wrap_dummy_oe");
    sqi_rd(rb, soe); chk("wrap_ffff", {24'd0, rb}, 32'hA1);
    sqi_rd(rb, soe); chk("wrap_0000", {24'd0, rb}, 32'hB2);
    sqi_rd(rb, soe); chk("wrap_0001", {24'd0, rb}, 32'hC3);
    cs_off;
    sqi_hdr(8'h03, 24'hAB0000); dummies("hiaddr_dummy_oe");
    sqi_rd(rb, soe); chk("hiaddr_ignored", {24'd0, rb}, 32'hB2);
    cs_off;

    sqi_hdr(8'h02, 24'h000020); sqi_byte(8'h77); cs_off;
    we0 = we_cnt;
    sqi_hdr(8'h02, 24'h000020);
    beat(4'h9, so, soe);
    cs_n = 1'b1;
    clks(3);
    chk("abort_idle", {29'd0, dut.r_state}, 32'd0);
    clks(6);
    chk("abort_no_write", we_cnt, we0);
    chk("abort_mode_kept", {31'd0, dut.r_mode}, 32'd1);
    sqi_hdr(8'h03, 24'h000020); dummies("abort_dummy_oe");
    sqi_rd(rb, soe); chk("abort_byte20", {24'd0, rb}, 32'h77);
    cs_off;

    we0 = we_cnt; oe0 = oe_hi;
    cs_on; sqi_byte(8'hA5);
    for (int i = 0; i < 20; i++) beat(4'(i), so, soe);
    chk("ign_state", {29'd0, dut.r_state}, 32'd6);
    cs_off;
    chk("ign_no_write", we_cnt, we0);
    chk("ign_no_oe", oe_hi, oe0);
    cs_on; sqi_byte(8'hFF); cs_off;
    chk("rstqio_mode", {31'd0, dut.r_mode}, 32'd0);

    oe0 = oe_hi; exp_b = 8'hB2;
    cs_on; spi_byte(8'h03); spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h00);
    for (int i = 7; i >= 0; i--) begin
      beat(4'h0, so, soe);
`ifdef QSPI_RESP_SPI_RW_EN
      chk("spi_rd_bit", {28'd0, so}, {28'd0, 2'b00, exp_b[i], 1'b0});
      chk("spi_rd_oe", {31'd0, soe}, 32'd1);
`else
      chk("spi_rd_sio_o", {28'd0, so}, 32'd0);
      chk("spi_rd_oe", {31'd0, soe}, 32'd0);
`endif
    end
    cs_off;
`ifndef QSPI_RESP_SPI_RW_EN
    chk("spi_rd_no_oe", oe_hi, oe0);
`endif

    cs_on; spi_byte(8'h38); cs_off;
    cs_on; sqi_byte(8'h02); beat(4'h0, so, soe);
    reset_n = 1'b0;
    clks(2);
    chk("midrst_state", {29'd0, dut.r_state}, 32'd0);
    chk("midrst_mode", {31'd0, dut.r_mode}, 32'd0);
    chk("midrst_oe", {31'd0, oe}, 32'd0);
    cs_n = 1'b1; sck = 1'b0;
    clks(2);
    reset_n = 1'b1;
    clks(2);
    cs_on; spi_byte(8'h38); cs_off;
    chk("postrst_eqio", {31'd0, dut.r_mode}, 32'd1);

    chk("oe_only_rdata", oe_bad, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/qspi_sram_responder.md
QSPI_SRAM_RESPONDER -- requirements
Module: qspi_sram_responder

Interface
REQ-001 SHALL have parameter MEM_ADDR_WIDTH, default 16, meaning the internal byte array holds 2^MEM_ADDR_WIDTH bytes.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth on cs_n, sck and sio_i.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port sram_cs_n, input, 1 bit: chip select from the initiator, active low.
REQ-006 SHALL have port sram_sck, input, 1 bit: serial clock from the initiator.
REQ-007 SHALL have port sram_sio_i, input, 4 bits: SIO[3:0] as driven by the initiator.
REQ-008 SHALL have port sram_sio_o, output, 4 bits: SIO[3:0] data driven toward the initiator.
REQ-009 SHALL have port sram_sio_oe, output, 1 bit: high when the responder drives SIO.

Function
REQ-010 SHALL oversample all inputs through SYNC_STAGES flops and detect sck rising and falling edges in the clk domain; sck high and low phases are each at least 4 clk periods.
REQ-011 SHALL hold a mode flag, SPI or SQI; SPI shifts 1 bit per sck rise on sio0 (MSB first); SQI shifts 1 nibble per sck rise on sio[3:0] (sio3 = MSB, high nibble first).
REQ-012 SHALL run an FSM with states IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
REQ-013 SHALL move from IDLE to CMD on the synchronized cs_n falling edge, clearing the shift counter.
REQ-014 CMD SHALL collect 8 bits, then decode: 0x03 READ -> ADDR; 0x02 WRITE -> ADDR; 0x38 EQIO -> mode=SQI, IGNORE; 0xFF RSTQIO -> mode=SPI, IGNORE; any other opcode -> IGNORE.
REQ-015 ADDR SHALL collect 24 bits (24 sck in SPI, 6 in SQI); only the low MEM_ADDR_WIDTH bits are used and the upper bits are ignored.
REQ-016 After ADDR, READ SHALL go to DUMMY in SQI (2 sck rises discarded), or directly to RDATA in SPI; WRITE SHALL go to WDATA.
REQ-017 RDATA SHALL fetch the addressed byte, present its first bit/nibble before the first data sck rise, and update sram_sio_o within 3 clk of each sck fall.
REQ-018 WDATA SHALL commit a byte to the array on the sck rise that completes the 8th bit or 2nd nibble.
REQ-019 After each complete byte, the address SHALL increment by 1 and wrap from 2^MEM_ADDR_WIDTH-1 to 0 (sequential mode only).
REQ-020 sram_sio_oe SHALL be high only in RDATA while cs_n is low; in SPI mode only sio1 carries data and sio_o[3:2,0] are 0.
REQ-021 A cs_n rise in any state SHALL return the FSM to IDLE within SYNC_STAGES+1 clk, drop sio_oe, and discard any partial write byte; the mode flag is kept.
REQ-022 A cs_n rise coincident with a byte-completing sck rise SHALL still commit that byte.
REQ-023 IGNORE SHALL discard all sck activity until cs_n rises.

Reset
REQ-024 While reset_n is low: FSM=IDLE, mode=SPI, counters=0, address=0, sram_sio_o=0, sram_sio_oe=0; array contents are undefined and not cleared.
REQ-025 Reset asserted mid-transaction SHALL abort it; after release, the first cs_n falling edge starts a new CMD.

Configuration
REQ-026 Macro QSPI_RESP_SPI_RW_EN: when defined, READ/WRITE SHALL be honoured in SPI mode as well; when undefined, READ/WRITE in SPI mode SHALL go to IGNORE, and only EQIO/RSTQIO are accepted in SPI mode.

Structure
REQ-027 Package qspi_sram_pkg SHALL hold the opcode constants (READ, WRITE, EQIO, RSTQIO), the FSM state encoding and the dummy-cycle count; spi_sram_encoder SHALL share the opcodes.
REQ-028 Sub-module qspi_resp_mem SHALL implement the byte array with 1 synchronous write port and 1 synchronous read port.

Verification
REQ-029 After reset, SPI-send 0x38, raise cs_n -> mode=SQI; a following SQI READ sees sio_oe high only in RDATA.
REQ-030 SQI WRITE to address 0x000010 with data 0x12,0x34 (16-bit word), then SQI READ at 0x000010 -> nibbles 1,2,3,4 returned after 2 dummy clocks.
REQ-031 SQI WRITE of 3 bytes at 0x00FFFF with MEM_ADDR_WIDTH=16 -> bytes land at 0xFFFF, 0x0000, 0x0001; reading back from 0xFFFF returns the same data.
REQ-032 cs_n raised after the first data nibble of a WRITE to 0x20 -> byte 0x20 unchanged; FSM is IDLE within 3 clk.
REQ-033 SQI opcode 0xA5 followed by 20 sck -> no writes and sio_oe stays 0; SQI 0xFF -> mode=SPI.
REQ-034 With QSPI_RESP_SPI_RW_EN undefined, SPI READ 0x03 at 0x000000 -> sio_oe stays 0; with it defined -> byte returned MSB first on sio1.
